ppu_row_buffer: RTL and testbench
=================================

Name: ppu_row_buffer

Overview:
Double-buffered row RAM between the PPU row renderer (writer) and the HDMI video output stage (reader). The front buffer is read by the video output one pixel index per address. The PPU fills the back buffer with 10-bit palette indices for the next 320-pixel row. On rowram_swap the buffers exchange roles. The new back buffer is then auto-cleared to a backdrop index before the PPU may write it. Underruns are flagged when a swap arrives before the PPU finishes its row.

Parameters:
ROW_WIDTH, 320, visible pixels per row (valid addresses 0..ROW_WIDTH-1)
ADDR_W, 9, address width of read and write ports
DATA_W, 10, palette-index width
CLEAR_VALUE, 10'd0, backdrop index written during clear and returned for out-of-range reads

Ports:
video_clk  in  1  sole clock; PPU write side also runs on it
rst_n  in  1  asynchronous, active-low reset
rowram_swap  in  1  single-cycle pulse from video output; exchange front/back
rowram_rdaddr  in  ADDR_W  front-buffer read address
rowram_rddata  out  DATA_W  registered front-buffer read data
wr_valid  in  1  PPU write request
wr_ready  out  1  back buffer accepting writes
wr_addr  in  ADDR_W  back-buffer pixel address
wr_data  in  DATA_W  palette index to write
wr_row_done  in  1  pulse: PPU finished current back row
row_complete  out  1  back buffer holds a finished row
underrun  out  1  sticky: swap occurred before row_complete
underrun_clr  in  1  clears underrun

Behaviour:
- Storage: two ROW_WIDTH x DATA_W simple dual-port RAMs (buf0, buf1). front_sel selects the front buffer; back = ~front_sel.
- Reset values: front_sel=0, state=CLEAR, clr_addr=0, rowram_rddata=0, wr_ready=0, row_complete=0, underrun=0. Reset is asynchronous and may assert mid-clear or mid-fill; all state returns to these values.
- Reset-initiated clear writes CLEAR_VALUE to both buffers in parallel. Later clears write only the back buffer.
- Read path: 1-cycle latency. rowram_rddata at cycle N+1 = front[rowram_rdaddr at cycle N], using front_sel as of cycle N.
- Read path: rowram_rdaddr >= ROW_WIDTH returns CLEAR_VALUE.
- Read path: a read in the swap cycle uses the pre-swap front buffer.
- FSM states: CLEAR, FILL, DONE.
- CLEAR: writes CLEAR_VALUE to back[clr_addr] each cycle, clr_addr 0..ROW_WIDTH-1. After writing ROW_WIDTH-1, go to FILL. Duration is exactly ROW_WIDTH cycles. wr_ready=0.
- FILL: wr_ready = !rowram_swap (combinational). A write fires on wr_valid && wr_ready.
- FILL write address: wr_addr >= ROW_WIDTH is accepted but discarded (no RAM write).
- FILL: wr_row_done goes to DONE; a write in the same cycle is still performed.
- DONE: row_complete=1 and wr_ready=0. wr_row_done and wr_valid are ignored.
- Swap, any state: front_sel toggles, clr_addr<=0, state<=CLEAR, row_complete<=0. Any write in the swap cycle is dropped.
- Swap underrun: if state was not DONE at the swap, underrun<=1. This covers a swap mid-clear, which restarts the clear at address 0.
- underrun_clr clears underrun. If set and clear coincide, set wins.
- Budget: swap comes once per 1600 cycles (two 800-cycle lines). The clear takes 320, leaving the PPU 1280 cycles to fill.

Test Plan:
- Reset then idle: drop rst_n for 3 cycles, release. wr_ready rises exactly 320 cycles later. Reading addr 0, 100, 319 returns 0 one cycle after each address.
- Fill and swap: write addr k with data k+5 for k=0..319, pulse wr_row_done. row_complete=1 and underrun stays 0. Pulse rowram_swap, then read addr 7 → rddata 12 next cycle. Out-of-range addr 400 → 0.
- Back buffer isolation: after the swap above, write addr 7 = 10'h3FF in the new back buffer. Front read of addr 7 still returns 12. After a second swap, the back buffer read is cleared (0), not 10'h3FF from the old row.
- Underrun: swap while in FILL with only 10 writes done. underrun=1 next cycle and stays 1. underrun_clr alone clears it. underrun_clr coincident with a new early swap leaves underrun=1.
- Simultaneous events: wr_valid with addr 5 in the same cycle as rowram_swap → wr_ready=0 that cycle and the write is not stored. wr_valid with wr_row_done (addr 319, data 9) → stored, state DONE.
- Reset mid-fill: assert rst_n low after 50 writes. All outputs return to reset values immediately (async). front_sel=0, and both buffers read 0 after the 320-cycle clear.

Source files
------------

// File: rtl/ppu_row_buffer.sv
// Double-buffered 320-pixel row RAM between the PPU row renderer and the HDMI
// output. The front buffer is read by video; the back buffer is auto-cleared,
// then filled by the PPU.
module ppu_row_buffer #(
  parameter int                 ROW_WIDTH   = 320,
  parameter int                 ADDR_W      = 9,
  parameter int                 DATA_W      = 10,
  parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
  input  logic              video_clk,
  input  logic              rst_n,
  input  logic              rowram_swap,
  input  logic [ADDR_W-1:0] rowram_rdaddr,
  output logic [DATA_W-1:0] rowram_rddata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_row_done,
  output logic              row_complete,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic [1:0]        dbg_state,
  output logic              dbg_front_sel
);

  // Write handshake: a pixel is accepted on a cycle where wr_valid && wr_ready.
  // wr_ready is high only in FILL and drops combinationally on a swap cycle.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FILL  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ROW_LIM  = ADDR_W'(ROW_WIDTH);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROW_WIDTH - 1);

  state_t            state, state_n;
  logic              front_sel;
  logic              init_clear, init_clear_n;
  logic [ADDR_W-1:0] clr_addr, clr_addr_n;

  logic [DATA_W-1:0] buf0 [ROW_WIDTH];
  logic [DATA_W-1:0] buf1 [ROW_WIDTH];

  logic              clr_we, fill_we, we0, we1;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    state_n      = state;
    clr_addr_n   = clr_addr;
    init_clear_n = init_clear;
    wr_ready     = 1'b0;
    row_complete = 1'b0;
    clr_we       = 1'b0;
    fill_we      = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we     = !rowram_swap;
        clr_addr_n = clr_addr + 1'b1;
        if (clr_addr == ROW_LAST) begin
          state_n      = ST_FILL;
          init_clear_n = 1'b0;
        end
      end
      ST_FILL: begin
        wr_ready = !rowram_swap;
        fill_we  = wr_valid && wr_ready && (wr_addr < ROW_LIM);
        if (wr_row_done) state_n = ST_DONE;
      end
      ST_DONE: row_complete = 1'b1;
      default: state_n = ST_CLEAR;
    endcase
    // A swap overrides everything: restart the clear on the new back buffer.
    if (rowram_swap) begin
      state_n      = ST_CLEAR;
      clr_addr_n   = '0;
      init_clear_n = 1'b0;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clr_addr   <= '0;
      init_clear <= 1'b1;
      front_sel  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      clr_addr   <= clr_addr_n;
      init_clear <= init_clear_n;
      if (rowram_swap) front_sel <= !front_sel;
      if (rowram_swap && state != ST_DONE) underrun <= 1'b1;
      else if (underrun_clr)               underrun <= 1'b0;
    end
  end

  // The back buffer is buf0 when front_sel=1; the post-reset clear hits both.
  assign we0       = (clr_we && (init_clear || front_sel)) || (fill_we && front_sel);
  assign we1       = (clr_we && (init_clear || !front_sel)) || (fill_we && !front_sel);
  assign ram_waddr = clr_we ? clr_addr : wr_addr;
  assign ram_wdata = clr_we ? CLEAR_VALUE : wr_data;

  always_ff @(posedge video_clk) begin
    if (we0) buf0[ram_waddr] <= ram_wdata;
  end

  always_ff @(posedge video_clk) begin
    if (we1) buf1[ram_waddr] <= ram_wdata;
  end

  assign rd_word = front_sel ? buf1[rowram_rdaddr] : buf0[rowram_rdaddr];

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n)                       rowram_rddata <= '0;
    else if (rowram_rdaddr < ROW_LIM) rowram_rddata <= rd_word;
    else                              rowram_rddata <= CLEAR_VALUE;
  end

  assign dbg_state     = state;
  assign dbg_front_sel = front_sel;

endmodule

// File: tb/tb_ppu_row_buffer.sv
// Directed bench for ppu_row_buffer: read-vector table plus hand-written
// sequences for swap, underrun, simultaneous-event and async-reset corners.
module tb_ppu_row_buffer;

  logic       video_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rowram_swap = 1'b0;
  logic [8:0] rowram_rdaddr = '0;
  logic [9:0] rowram_rddata;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [8:0] wr_addr = '0;
  logic [9:0] wr_data = '0;
  logic       wr_row_done = 1'b0;
  logic       row_complete;
  logic       underrun;
  logic       underrun_clr = 1'b0;
  logic [1:0] dbg_state;
  logic       dbg_front_sel;

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic [8:0] addr;
    logic [9:0] exp;
  } rd_vec_t;

  rd_vec_t rv [6];

  ppu_row_buffer dut (
    .video_clk    (video_clk),
    .rst_n        (rst_n),
    .rowram_swap  (rowram_swap),
    .rowram_rdaddr(rowram_rdaddr),
    .rowram_rddata(rowram_rddata),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_row_done  (wr_row_done),
    .row_complete (row_complete),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .dbg_state    (dbg_state),
    .dbg_front_sel(dbg_front_sel)
  );

  // clock / reset
  always #5 video_clk = ~video_clk;

  task automatic tick();
    @(posedge video_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic rd(input logic [8:0] addr, input logic [9:0] exp, input string name);
    rowram_rdaddr = addr;
    tick();
    check(name, 32'(rowram_rddata), 32'(exp));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic write_px(input logic [8:0] addr, input logic [9:0] data);
    wr_valid = 1'b1;
    wr_addr  = addr;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic finish_row();
    wr_row_done = 1'b1;
    tick();
    wr_row_done = 1'b0;
  endtask

  task automatic swap();
    rowram_swap = 1'b1;
    tick();
    rowram_swap = 1'b0;
  endtask

  initial begin
    int n;
    rv[0] = '{addr: 9'd7,   exp: 10'd12};
    rv[1] = '{addr: 9'd400, exp: 10'd0};
    rv[2] = '{addr: 9'd0,   exp: 10'd5};
    rv[3] = '{addr: 9'd319, exp: 10'd324};
    rv[4] = '{addr: 9'd100, exp: 10'd105};
    rv[5] = '{addr: 9'd320, exp: 10'd0};

    // reset then idle
    repeat (3) tick();
    check("rst_rddata", 32'(rowram_rddata), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_row_complete", 32'(row_complete), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_front_sel", 32'(dbg_front_sel), 0);
    rst_n = 1'b1;
    wait_ready(n);
    check("init_clear_len", n, 320);
    rd(9'd0, 10'd0, "idle_rd0");
    rd(9'd100, 10'd0, "idle_rd100");
    rd(9'd319, 10'd0, "idle_rd319");

    // fill and swap
    for (int k = 0; k < 320; k++) write_px(9'(k), 10'(k + 5));
    finish_row();
    check("fill_row_complete", 32'(row_complete), 1);
    check("fill_wr_ready_done", 32'(wr_ready), 0);
    check("fill_underrun", 32'(underrun), 0);
    rowram_rdaddr = 9'd7;
    swap();
    check("swap_cycle_read_old_front", 32'(rowram_rddata), 0);
    check("swap_no_underrun", 32'(underrun), 0);
    check("swap_row_complete_clr", 32'(row_complete), 0);
    check("swap_front_sel", 32'(dbg_front_sel), 1);
    for (int i = 0; i < 6; i++) begin
      rowram_rdaddr = rv[i].addr;
      tick();
      check($sformatf("vec_rd[%0d]", i), 32'(rowram_rddata), 32'(rv[i].exp));
    end
    wait_ready(n);
    check("swap_clear_len", n + 6, 320);

    // back buffer isolation
    write_px(9'd7, 10'h3FF);
    rd(9'd7, 10'd12, "iso_front_kept");
    finish_row();
    swap();
    rd(9'd7, 10'h3FF, "iso_new_front");
    wait_ready(n);
    finish_row();
    swap();
    rd(9'd7, 10'd0, "iso_old_row_cleared");
    check("iso_no_underrun", 32'(underrun), 0);

    // underrun
    wait_ready(n);
    for (int k = 0; k < 10; k++) write_px(9'(k), 10'(k + 1));
    swap();
    check("underrun_set", 32'(underrun), 1);
    repeat (5) tick();
    check("underrun_sticky", 32'(underrun), 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("underrun_clr", 32'(underrun), 0);
    repeat (100) tick();
    underrun_clr = 1'b1;
    rowram_swap  = 1'b1;
    tick();
    underrun_clr = 1'b0;
    rowram_swap  = 1'b0;
    check("underrun_set_wins", 32'(underrun), 1);
    wait_ready(n);
    check("midclear_swap_restart_len", n, 320);

    // simultaneous events
    wr_valid    = 1'b1;
    wr_addr     = 9'd5;
    wr_data     = 10'd77;
    rowram_swap = 1'b1;
    #1;
    check("swap_blocks_wr_ready", 32'(wr_ready), 0);
    tick();
    wr_valid    = 1'b0;
    rowram_swap = 1'b0;
    rd(9'd5, 10'd0, "swap_write_dropped");
    wait_ready(n);
    wr_valid    = 1'b1;
    wr_addr     = 9'd319;
    wr_data     = 10'd9;
    wr_row_done = 1'b1;
    tick();
    wr_valid    = 1'b0;
    wr_row_done = 1'b0;
    check("done_state", 32'(dbg_state), 2);
    check("done_row_complete", 32'(row_complete), 1);
    write_px(9'd319, 10'd55);
    swap();
    rd(9'd319, 10'd9, "done_write_stored");

    // reset mid-fill
    wait_ready(n);
    for (int k = 0; k < 50; k++) write_px(9'(k), 10'(k + 100));
    check("pre_reset_underrun", 32'(underrun), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rddata", 32'(rowram_rddata), 0);
    check("async_rst_wr_ready", 32'(wr_ready), 0);
    check("async_rst_underrun", 32'(underrun), 0);
    check("async_rst_state", 32'(dbg_state), 0);
    check("async_rst_front_sel", 32'(dbg_front_sel), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready(n);
    check("rst2_clear_len", n, 320);
    rd(9'd0, 10'd0, "rst2_buf0_rd0");
    rd(9'd49, 10'd0, "rst2_buf0_rd49");
    finish_row();
    swap();
    rd(9'd0, 10'd0, "rst2_buf1_rd0");
    rd(9'd49, 10'd0, "rst2_buf1_rd49");
    rd(9'd319, 10'd0, "rst2_buf1_rd319");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
